// File: rtl/sram_bridge.sv
// 6502 bus responder for an asynchronous 8-bit SRAM page with programmable wait states.
// Optional bank register at offset 0xFFF when SRAM_BRIDGE_BANK_EN is defined.
module sram_bridge #(
    parameter int RD_WAIT = 2,
    parameter int WR_WAIT = 1,
    parameter int BANK_W  = 7
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cs,
    input  logic                  we,
    input  logic [11:0]           ab,
    input  logic [7:0]            din,
    output logic [7:0]            dout,
    output logic                  rdy,
    output logic [12+BANK_W-1:0]  sram_addr,
    output logic                  sram_ce_n,
    output logic                  sram_oe_n,
    output logic                  sram_we_n,
    output logic [7:0]            sram_d_o,
    output logic                  sram_d_oe,
    input  logic [7:0]            sram_d_i
);

    typedef enum logic [2:0] {
        S_IDLE,
        S_RD,
        S_WR_SETUP,
        S_WR_PULSE,
        S_WR_HOLD
    } state_t;

    state_t                 r_state;
    logic [3:0]             r_cnt;
    logic                   r_we;
    logic                   r_bank_acc;
    logic [7:0]             r_din;
    logic [7:0]             r_dout;
    logic [12+BANK_W-1:0]   r_addr;
    logic                   r_ce_n;
    logic                   r_oe_n;
    logic                   r_we_n;
    logic                   r_d_oe;

    logic [BANK_W-1:0]      w_bank;
    logic                   w_bank_hit;
    logic [7:0]             w_bank_rd;

`ifdef SRAM_BRIDGE_BANK_EN
    logic [BANK_W-1:0]      r_bank;

    // Bank write lands on the single RD-state edge of a bank access.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_bank <= '0;
        end else if (r_state == S_RD && r_bank_acc && r_we && r_cnt == 4'd0) begin
            r_bank <= r_din[BANK_W-1:0];
        end
    end

    assign w_bank     = r_bank;
    assign w_bank_hit = (ab == 12'hFFF);
`else
    assign w_bank     = '0;
    assign w_bank_hit = 1'b0;
`endif

    assign w_bank_rd = 8'(w_bank);

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_cnt      <= 4'd0;
            r_we       <= 1'b0;
            r_bank_acc <= 1'b0;
            r_din      <= 8'h00;
            r_dout     <= 8'h00;
            r_addr     <= '0;
            r_ce_n     <= 1'b1;
            r_oe_n     <= 1'b1;
            r_we_n     <= 1'b1;
            r_d_oe     <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (cs) begin
                        r_addr     <= {w_bank, ab};
                        r_din      <= din;
                        r_we       <= we;
                        r_bank_acc <= w_bank_hit;
                        if (w_bank_hit) begin
                            // Register access: one RD cycle with no strobes.
                            r_state <= S_RD;
                            r_cnt   <= 4'd0;
                        end else if (we) begin
                            r_state <= S_WR_SETUP;
                            r_ce_n  <= 1'b0;
                            r_d_oe  <= 1'b1;
                        end else begin
                            r_state <= S_RD;
                            r_cnt   <= 4'(RD_WAIT);
                            r_ce_n  <= 1'b0;
                            r_oe_n  <= 1'b0;
                        end
                    end
                end
                S_RD: begin
                    if (r_cnt == 4'd0) begin
                        if (!r_we) begin
                            r_dout <= r_bank_acc ? w_bank_rd : sram_d_i;
                        end
                        r_ce_n  <= 1'b1;
                        r_oe_n  <= 1'b1;
                        r_state <= S_IDLE;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WR_SETUP: begin
                    r_state <= S_WR_PULSE;
                    r_cnt   <= 4'(WR_WAIT);
                    r_we_n  <= 1'b0;
                end
                S_WR_PULSE: begin
                    if (r_cnt == 4'd0) begin
                        r_we_n  <= 1'b1;
                        r_state <= S_WR_HOLD;
                    end else begin
                        r_cnt <= r_cnt - 4'd1;
                    end
                end
                S_WR_HOLD: begin
                    r_ce_n  <= 1'b1;
                    r_d_oe  <= 1'b0;
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    assign rdy       = (r_state == S_IDLE);
    assign dout      = r_dout;
    assign sram_addr = r_addr;
    assign sram_ce_n = r_ce_n;
    assign sram_oe_n = r_oe_n;
    assign sram_we_n = r_we_n;
    assign sram_d_o  = r_din;
    assign sram_d_oe = r_d_oe;

endmodule

// File: tb/tb_sram_bridge.sv
// Directed bench for sram_bridge: vector table of single accesses plus hand-written
// sequences for held requests, reset mid-write and the optional bank register.
module tb_sram_bridge;

    localparam int RDW = 2;
    localparam int WRW = 1;
    localparam int BW  = 7;
    localparam int AW  = 12 + BW;

    logic          clk = 1'b0;
    logic          reset;
    logic          cs;
    logic          we;
    logic [11:0]   ab;
    logic [7:0]    din;
    logic [7:0]    dout;
    logic          rdy;
    logic [AW-1:0] sram_addr;
    logic          sram_ce_n;
    logic          sram_oe_n;
    logic          sram_we_n;
    logic [7:0]    sram_d_o;
    logic          sram_d_oe;
    logic [7:0]    sram_d_i;

    sram_bridge #(.RD_WAIT(RDW), .WR_WAIT(WRW), .BANK_W(BW)) dut (
        .clk       (clk),
        .reset     (reset),
        .cs        (cs),
        .we        (we),
        .ab        (ab),
        .din       (din),
        .dout      (dout),
        .rdy       (rdy),
        .sram_addr (sram_addr),
        .sram_ce_n (sram_ce_n),
        .sram_oe_n (sram_oe_n),
        .sram_we_n (sram_we_n),
        .sram_d_o  (sram_d_o),
        .sram_d_oe (sram_d_oe),
        .sram_d_i  (sram_d_i)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM model: reads while CE and OE low, write latched on WE rising.
    logic [7:0] mem [0:(1<<AW)-1];
    int         n_wr   = 0;
    bit         mon_en = 1'b0;

    assign sram_d_i = (!sram_ce_n && !sram_oe_n) ? mem[sram_addr] : 8'hEE;

    initial begin
        mem[19'h00123] = 8'hA5;
        mem[19'h007FF] = 8'h5A;
        mem[19'h05010] = 8'h77;
        forever begin
            @(posedge sram_we_n);
            if (mon_en && !sram_ce_n) begin
                mem[sram_addr] = sram_d_o;
                n_wr++;
            end
        end
    end

    typedef struct {
        logic          w;
        logic [11:0]   a;
        logic [7:0]    d;
        logic [AW-1:0] exp_addr;
        int            exp_busy;
        int            exp_ce;
        int            exp_oe;
        int            exp_we;
        int            exp_doe;
        logic [7:0]    exp_dout;
    } vec_t;

    vec_t vecs[$];
    int   n_vec = 0;
    int   n_bad = 0;

    function automatic vec_t mk_rd(logic [11:0] a, logic [7:0] data);
        vec_t v;
        v.w = 1'b0; v.a = a; v.d = 8'h00; v.exp_addr = AW'(a);
        v.exp_busy = RDW + 1; v.exp_ce = RDW + 1; v.exp_oe = RDW + 1;
        v.exp_we = 0; v.exp_doe = 0; v.exp_dout = data;
        return v;
    endfunction

    function automatic vec_t mk_wr(logic [11:0] a, logic [7:0] d, logic [7:0] prev_dout);
        vec_t v;
        v.w = 1'b1; v.a = a; v.d = d; v.exp_addr = AW'(a);
        v.exp_busy = WRW + 3; v.exp_ce = WRW + 3; v.exp_oe = 0;
        v.exp_we = WRW + 1; v.exp_doe = WRW + 3; v.exp_dout = prev_dout;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h, expected %0h", nm, act, exp);
        end
    endtask

    // One access from an idle bus; counts strobe cycles until rdy returns.
    task automatic access(input logic w, input logic [11:0] a, input logic [7:0] d,
                          input bit hold, output int busy, output int ce, output int oe,
                          output int wel, output int doe, output int clash,
                          output logic [AW-1:0] addr1, output logic [7:0] do1);
        busy = 0; ce = 0; oe = 0; wel = 0; doe = 0; clash = 0;
        addr1 = '0; do1 = 8'h00;
        cs = 1'b1; we = w; ab = a; din = d;
        @(posedge clk); #1;
        if (!hold) cs = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(negedge clk);
            if (k == 1) begin
                addr1 = sram_addr;
                do1   = sram_d_o;
            end
            if (!sram_ce_n) ce++;
            if (!sram_oe_n) oe++;
            if (!sram_we_n) wel++;
            if (sram_d_oe) doe++;
            if (!sram_oe_n && sram_d_oe) clash++;
            if (rdy) break;
            busy++;
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " rdy"},   rdy,       1);
        chk({tag, " ce_n"},  sram_ce_n, 1);
        chk({tag, " oe_n"},  sram_oe_n, 1);
        chk({tag, " we_n"},  sram_we_n, 1);
        chk({tag, " d_oe"},  sram_d_oe, 0);
        chk({tag, " d_o"},   sram_d_o,  0);
        chk({tag, " addr"},  sram_addr, 0);
        chk({tag, " dout"},  dout,      0);
    endtask

    initial begin
        int            busy, ce, oe, wel, doe, clash, wr0, busy2;
        logic [AW-1:0] addr1;
        logic [7:0]    do1;

        // Reset asserted together with a pending request.
        reset = 1'b1; cs = 1'b1; we = 1'b1; ab = 12'h456; din = 8'hFF;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0; cs = 1'b0;
        mon_en = 1'b1;
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            n_vec++;
            chk_reset_vals($sformatf("idle%0d", c));
        end

        vecs.push_back(mk_wr(12'h456, 8'h3C, 8'h00));
        vecs.push_back(mk_rd(12'h123, 8'hA5));
        vecs.push_back(mk_rd(12'h456, 8'h3C));
        vecs.push_back(mk_wr(12'h000, 8'h00, 8'h3C));
        vecs.push_back(mk_rd(12'h000, 8'h00));
        vecs.push_back(mk_wr(12'hFFE, 8'hFF, 8'h00));
        vecs.push_back(mk_rd(12'hFFE, 8'hFF));
        vecs.push_back(mk_rd(12'h7FF, 8'h5A));
`ifndef SRAM_BRIDGE_BANK_EN
        vecs.push_back(mk_wr(12'hFFF, 8'h99, 8'h5A));
        vecs.push_back(mk_rd(12'hFFF, 8'h99));
`endif

        foreach (vecs[i]) begin
            access(vecs[i].w, vecs[i].a, vecs[i].d, 1'b0,
                   busy, ce, oe, wel, doe, clash, addr1, do1);
            n_vec++;
            chk($sformatf("v%0d busy", i),  busy,  vecs[i].exp_busy);
            chk($sformatf("v%0d ce", i),    ce,    vecs[i].exp_ce);
            chk($sformatf("v%0d oe", i),    oe,    vecs[i].exp_oe);
            chk($sformatf("v%0d we", i),    wel,   vecs[i].exp_we);
            chk($sformatf("v%0d doe", i),   doe,   vecs[i].exp_doe);
            chk($sformatf("v%0d clash", i), clash, 0);
            chk($sformatf("v%0d addr", i),  addr1, vecs[i].exp_addr);
            chk($sformatf("v%0d dout", i),  dout,  vecs[i].exp_dout);
            if (vecs[i].w) chk($sformatf("v%0d d_o", i), do1, vecs[i].d);
        end

        // Write held through the stall, then a read in the first idle cycle.
        wr0 = n_wr;
        access(1'b1, 12'h234, 8'h6B, 1'b1, busy, ce, oe, wel, doe, clash, addr1, do1);
        we = 1'b0; ab = 12'h234;
        @(negedge clk);
        n_vec++;
        chk("hold wbusy", busy, WRW + 3);
        chk("hold accept rdy", rdy, 0);
        chk("hold accept oe_n", sram_oe_n, 0);
        cs = 1'b0;
        busy2 = 1;
        for (int k = 0; k < 20; k++) begin
            if (rdy) break;
            @(negedge clk);
            if (!rdy) busy2++;
        end
        chk("hold rbusy", busy2, RDW + 1);
        chk("hold dout", dout, 8'h6B);
        chk("hold nwr", n_wr - wr0, 1);

        // Reset in the middle of the write pulse.
        cs = 1'b1; we = 1'b1; ab = 12'h300; din = 8'h11;
        @(posedge clk); #1;
        cs = 1'b0;
        @(negedge clk);
        @(negedge clk);
        n_vec++;
        chk("abort pulse we_n", sram_we_n, 0);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        chk_reset_vals("abort");
        access(1'b0, 12'h123, 8'h00, 1'b0, busy, ce, oe, wel, doe, clash, addr1, do1);
        n_vec++;
        chk("post-abort busy", busy, RDW + 1);
        chk("post-abort oe", oe, RDW + 1);
        chk("post-abort dout", dout, 8'hA5);

`ifdef SRAM_BRIDGE_BANK_EN
        access(1'b1, 12'hFFF, 8'h05, 1'b0, busy, ce, oe, wel, doe, clash, addr1, do1);
        n_vec++;
        chk("bankwr busy", busy, 1);
        chk("bankwr ce", ce, 0);
        chk("bankwr we", wel, 0);
        chk("bankwr doe", doe, 0);
        access(1'b0, 12'h010, 8'h00, 1'b0, busy, ce, oe, wel, doe, clash, addr1, do1);
        n_vec++;
        chk("bank addr", addr1, 19'h05010);
        chk("bank data", dout, 8'h77);
        access(1'b0, 12'hFFF, 8'h00, 1'b0, busy, ce, oe, wel, doe, clash, addr1, do1);
        n_vec++;
        chk("bankrd busy", busy, 1);
        chk("bankrd ce", ce, 0);
        chk("bankrd dout", dout, 8'h05);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
